// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 64-bit machine timer with compare interrupt.
// Optional MTIME high-word snapshot on low-word loads: define MMIO_TIMER_SNAPSHOT_EN.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0200_0000,
    parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable_n,
    input  logic        is_write,
    input  logic        is_unsigned,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        op_fault,
    output logic        addr_fault,
    output logic        access_fault_n,
    output logic        irq
);
    logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [15:0] pre_q, pre_d, cnt_q, cnt_d;
    logic [31:0] out_q, out_d;
    logic        irq_q, irq_d;
    logic        active, ok, ld, st, st_time, tick;
    logic [2:0]  idx;
    logic [3:0]  lanes;
    logic [31:0] old_word, rword, shifted, bmask, wdata, new_word, hi_rd;

    assign active         = ~enable_n;
    assign op_fault       = active & (op == 2'b11);
    assign addr_fault     = active & ((op == 2'b01 & addr[0]) | (op == 2'b10 & (addr[1:0] != 2'b00)));
    assign access_fault_n = ~(active & (addr[31:5] != BASE_ADDR[31:5]));
    assign ok             = active & ~op_fault & ~addr_fault & access_fault_n;
    assign ld             = ok & ~is_write;
    assign st             = ok & is_write;
    assign idx            = addr[4:2];
    assign out            = out_q;
    assign irq            = irq_q;

`ifdef MMIO_TIMER_SNAPSHOT_EN
    logic [31:0] shadow_q;
    // Capture the pre-edge high word whenever software reads the low word
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) shadow_q <= '0;
        else if (ld && idx == 3'd0) shadow_q <= mtime_q[63:32];
    assign hi_rd = shadow_q;
`else
    assign hi_rd = mtime_q[63:32];
`endif

    // Live register word at the addressed slot; reserved slots read zero
    always_comb begin
        case (idx)
            3'd0:    old_word = mtime_q[31:0];
            3'd1:    old_word = mtime_q[63:32];
            3'd2:    old_word = cmp_q[31:0];
            3'd3:    old_word = cmp_q[63:32];
            3'd4:    old_word = {30'd0, ctrl_q};
            3'd5:    old_word = {16'd0, pre_q};
            default: old_word = '0;
        endcase
    end

    assign rword    = (idx == 3'd1) ? hi_rd : old_word;
    assign shifted  = rword >> {addr[1:0], 3'b000};
    assign lanes    = (op == 2'b00) ? (4'b0001 << addr[1:0]) : (op == 2'b01) ? (4'b0011 << addr[1:0]) : 4'b1111;
    assign bmask    = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    assign wdata    = (op == 2'b00) ? {4{in[7:0]}} : (op == 2'b01) ? {2{in[15:0]}} : in;
    assign new_word = (old_word & ~bmask) | (wdata & bmask);
    // A store to MTIME or PRESCALE pre-empts the tick and restarts the prescaler
    assign st_time  = st & (idx == 3'd0 | idx == 3'd1 | idx == 3'd5);
    assign tick     = ctrl_q[0] & (cnt_q == pre_q) & ~st_time;

    // Next-state: stores override ticking, loads update the read register
    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (st && idx == 3'd0) mtime_d[31:0] = new_word;
        if (st && idx == 3'd1) mtime_d[63:32] = new_word;
        cmp_d = cmp_q;
        if (st && idx == 3'd2) cmp_d[31:0] = new_word;
        if (st && idx == 3'd3) cmp_d[63:32] = new_word;
        ctrl_d = (st && idx == 3'd4) ? new_word[1:0] : ctrl_q;
        pre_d  = (st && idx == 3'd5) ? new_word[15:0] : pre_q;
        cnt_d  = (st_time | tick) ? 16'd0 : ctrl_q[0] ? cnt_q + 16'd1 : cnt_q;
        out_d  = !ld ? out_q :
                 (op == 2'b00) ? {{24{~is_unsigned & shifted[7]}}, shifted[7:0]} :
                 (op == 2'b01) ? {{16{~is_unsigned & shifted[15]}}, shifted[15:0]} : shifted;
        irq_d  = ctrl_q[1] & (mtime_q >= cmp_q);
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            mtime_q <= '0;
            cmp_q   <= '1;
            ctrl_q  <= '0;
            pre_q   <= PRESCALE_RESET;
            cnt_q   <= '0;
            out_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            irq_q   <= irq_d;
        end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed and random accesses checked against a byte-level timer model.
module tb_mmio_timer;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 0, reset_n = 0, enable_n = 1, is_write = 0, is_unsigned = 0;
    logic [1:0]  op = 0;
    logic [31:0] addr = 0, din = 0, out;
    logic        op_fault, addr_fault, access_fault_n, irq;

    logic [63:0] m_time, m_cmp;
    logic [1:0]  m_ctrl;
    logic [15:0] m_pre, m_cnt;
    logic [31:0] m_out, m_shadow;
    logic        m_irq;
    logic        s_of, s_af, s_acn;
    int          n_cmp = 0, n_bad = 0;

    mmio_timer dut (
        .clk(clk), .reset_n(reset_n), .enable_n(enable_n), .is_write(is_write),
        .is_unsigned(is_unsigned), .op(op), .addr(addr), .in(din), .out(out),
        .op_fault(op_fault), .addr_fault(addr_fault), .access_fault_n(access_fault_n), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_time = 0; m_cmp = '1; m_ctrl = 0; m_pre = 0; m_cnt = 0;
        m_out = 0; m_shadow = 0; m_irq = 0;
    endtask

    function automatic logic [31:0] m_word(input int w, input bit live);
        case (w)
            0: return m_time[31:0];
`ifdef MMIO_TIMER_SNAPSHOT_EN
            1: return live ? m_time[63:32] : m_shadow;
`else
            1: return m_time[63:32];
`endif
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {30'd0, m_ctrl};
            5: return {16'd0, m_pre};
            default: return 0;
        endcase
    endfunction

    task automatic m_put(input int w, input logic [31:0] v);
        case (w)
            0: m_time[31:0] = v;
            1: m_time[63:32] = v;
            2: m_cmp[31:0] = v;
            3: m_cmp[63:32] = v;
            4: m_ctrl = v[1:0];
            5: m_pre = v[15:0];
            default: ;
        endcase
    endtask

    // One bus cycle: drive, check faults, clock, advance model, check outputs
    task automatic access(input bit en, input bit wr, input bit uns, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] d);
        bit act, e_of, e_af, e_acn, ok, run, hit, tstore, nirq;
        int n, off;
        logic [31:0] v, cur;
        enable_n = en; is_write = wr; is_unsigned = uns; op = o; addr = a; din = d;
        act   = !en;
        e_of  = act && o == 2'd3;
        e_af  = act && ((o == 2'd1 && a[0]) || (o == 2'd2 && a[1:0] != 0));
        e_acn = !(act && (a[31:5] != BASE[31:5]));
        #1;
        s_of = op_fault; s_af = addr_fault; s_acn = access_fault_n;
        check("op_fault", op_fault, e_of);
        check("addr_fault", addr_fault, e_af);
        check("access_fault_n", access_fault_n, e_acn);
        @(posedge clk);
        ok = act && !e_of && !e_af && e_acn;
        nirq = m_ctrl[1] && (m_time >= m_cmp);
        run = m_ctrl[0];
        hit = (m_cnt == m_pre);
        tstore = 0;
        n = 1 << o;
        off = int'(a[4:0]);
        if (ok && !wr) begin
            v = m_word(off / 4, 0) >> (8 * (off % 4));
            if (n == 1) v = uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            if (n == 2) v = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            m_out = v;
            if (off / 4 == 0) m_shadow = m_time[63:32];
        end
        if (ok && wr) begin
            for (int i = 0; i < n; i++) begin
                cur = m_word((off + i) / 4, 1);
                cur[8 * ((off + i) % 4) +: 8] = d[8 * i +: 8];
                m_put((off + i) / 4, cur);
                if ((off + i) / 4 inside {0, 1, 5}) tstore = 1;
            end
        end
        if (tstore) m_cnt = 0;
        else if (run) begin
            if (hit) begin m_cnt = 0; m_time = m_time + 1; end
            else m_cnt = m_cnt + 1;
        end
        m_irq = nirq;
        #1;
        check("out", out, m_out);
        check("irq", irq, m_irq);
    endtask

    task automatic wr_w(input int o, input logic [31:0] d);
        access(0, 1, 0, 2'd2, BASE + o, d);
    endtask

    task automatic rd(input int o, input logic [1:0] sz, input bit uns);
        access(0, 0, uns, sz, BASE + o, 0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) access(1, 0, 0, 2'd0, 0, 0);
    endtask

    initial begin
        m_reset();
        #12;
        check("rst_out", out, 0);
        check("rst_irq", irq, 0);
        check("rst_acn", access_fault_n, 1);
        check("rst_of", op_fault, 0);
        check("rst_af", addr_fault, 0);
        @(negedge clk) reset_n = 1;
        idle(1);
        rd(8, 2'd2, 0);
        check("cmp_lo_reset", out, 32'hFFFF_FFFF);
        // prescaled ticking
        wr_w(20, 3);
        wr_w(16, 1);
        idle(40);
        rd(0, 2'd2, 0);
        check("presc_range", (out >= 9 && out <= 11), 1);
        // carry into high word
        wr_w(16, 0);
        wr_w(20, 0);
        wr_w(0, 32'hFFFF_FFFF);
        wr_w(4, 0);
        wr_w(16, 1);
        idle(1);
        rd(0, 2'd2, 0);
        check("carry_lo", out, 0);
        rd(4, 2'd2, 0);
        check("carry_hi", out, 1);
        // compare interrupt
        wr_w(16, 0);
        wr_w(0, 0);
        wr_w(4, 0);
        wr_w(12, 0);
        wr_w(8, 5);
        wr_w(16, 3);
        idle(12);
        check("irq_on", irq, 1);
        wr_w(8, 100);
        check("irq_hold", irq, 1);
        idle(1);
        check("irq_off", irq, 0);
        // byte store and sign extension
        wr_w(8, 32'hFFFF_FFFF);
        access(0, 1, 0, 2'd0, BASE + 10, 32'h0000_00AB);
        rd(10, 2'd0, 0);
        check("ld_sb", out, 32'hFFFF_FFAB);
        rd(10, 2'd0, 1);
        check("ld_ub", out, 32'h0000_00AB);
        rd(8, 2'd2, 0);
        check("cmp_byte", out, 32'hFFAB_FFFF);
        // faults leave state and out alone
        access(0, 1, 0, 2'd1, BASE + 1, 0);
        check("af_set", s_af, 1);
        check("af_out", out, 32'hFFAB_FFFF);
        access(0, 1, 0, 2'd3, BASE + 8, 0);
        check("of_set", s_of, 1);
        access(0, 1, 0, 2'd2, BASE + 32, 0);
        check("acn_clr", s_acn, 0);
        access(0, 0, 0, 2'd2, BASE + 32, 0);
        check("acn_out", out, 32'hFFAB_FFFF);
        rd(8, 2'd2, 0);
        check("cmp_kept", out, 32'hFFAB_FFFF);
        // random traffic
        wr_w(20, 1);
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, d;
            logic [1:0] o;
            o = ($urandom % 10 == 0) ? 2'd3 : 2'($urandom % 3);
            a = ($urandom % 12 == 0) ? $urandom : BASE + ($urandom % 32);
            d = ($urandom % 3 == 0) ? $urandom : $urandom % 8;
            access($urandom % 5 == 0, $urandom % 2, $urandom % 2, o, a, d);
        end
        // reset in the middle of a load
        enable_n = 0; is_write = 0; op = 2'd2; addr = BASE + 8;
        #2 reset_n = 0;
        #1;
        check("mid_rst_out", out, 0);
        check("mid_rst_irq", irq, 0);
        m_reset();
        @(posedge clk);
        #1;
        check("mid_rst_hold", out, 0);
        @(negedge clk) reset_n = 1;
        rd(8, 2'd2, 0);
        check("post_rst_cmp", out, 32'hFFFF_FFFF);
        rd(20, 2'd2, 0);
        check("post_rst_pre", out, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped machine timer and interrupt source.
- Acts as a responder on the core's data-memory port: same enable_n/is_write/is_unsigned/op/addr/in/out/fault signalling the core drives toward memory, seen from the target side.
- Holds a 64-bit prescaled time counter and a 64-bit compare register, and drives the core's ext_int line.

Parameters:
BASE_ADDR, 32'h0200_0000, byte address of the 32-byte register window; must be 32-byte aligned.
PRESCALE_RESET, 16'd0, reset value of the PRESCALE register.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_n  input  1  asynchronous active-low reset
enable_n  input  1  access request (active low), one access per cycle while low
is_write  input  1  1 = store, 0 = load
is_unsigned  input  1  load zero-extends when 1, sign-extends when 0
op  input  2  size: 00 byte, 01 half, 10 word, 11 illegal
addr  input  32  byte address
in  input  32  store data, right-aligned
out  output  32  load data, registered
op_fault  output  1  illegal op, combinational
addr_fault  output  1  misaligned access, combinational
access_fault_n  output  1  0 = address outside the window, combinational
irq  output  1  timer interrupt, level, registered; connects to ext_int

Behaviour:
- Reset (async, reset_n low):
  - MTIME = 0; MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF; CTRL = 0; PRESCALE = PRESCALE_RESET; prescale counter = 0.
  - out = 0; irq = 0.
- Register map (offset = addr − BASE_ADDR):
  - 0x00 MTIME[31:0]; 0x04 MTIME[63:32]; 0x08 MTIMECMP[31:0]; 0x0C MTIMECMP[63:32].
  - 0x10 CTRL: bit0 run, bit1 irq_en, others read 0.
  - 0x14 PRESCALE[15:0], upper bits read 0.
  - 0x18–0x1F: reserved; read 0, writes ignored, no fault.
- Faults: combinational, evaluated only while enable_n = 0. When idle: op_fault = 0, addr_fault = 0, access_fault_n = 1.
  - op_fault = (op == 11).
  - addr_fault = half with addr[0] = 1, or word with addr[1:0] != 0.
  - access_fault_n = 0 when addr[31:5] != BASE_ADDR[31:5].
  - Faults may assert simultaneously.
  - Any fault: no register write, out holds its previous value.
- Load (enable_n = 0, is_write = 0, no fault):
  - At the rising edge, out <= the selected byte/half of the 32-bit word at offset & 0x1C, right-aligned and extended per is_unsigned.
  - Latency: one edge; data valid in the cycle after the request.
- Store (no fault): byte lanes selected by op and addr[1:0] are written at the rising edge; unselected lanes are unchanged. out is unchanged.
- Tick:
  - When CTRL.run = 1, the prescale counter increments each cycle.
  - When counter == PRESCALE: counter <= 0 and MTIME <= MTIME + 1, wrapping 2^64−1 → 0 with no flag.
  - PRESCALE = 0 means MTIME increments every cycle.
- Store to MTIME (either half) or PRESCALE in the same cycle as a tick: the store wins, the tick is dropped, and the prescale counter resets to 0. A store to any other register does not disturb ticking.
- Carry from MTIME[31:0] into [63:32] is applied within the same tick (full 64-bit add).
- irq <= CTRL.irq_en & (MTIME >= MTIMECMP), unsigned 64-bit compare using current register values. The interrupt rises one cycle after the condition becomes true.
  - No sticky pending state; software clears irq by raising MTIMECMP or clearing irq_en.
- irq does not depend on CTRL.run.
- Reset mid-access: all state returns to reset values immediately; the in-flight access is discarded.

Optional Feature:
MMIO_TIMER_SNAPSHOT_EN
- Defined:
  - A non-faulting load from 0x00 also latches MTIME[63:32] (post-edge value excluded; pre-edge value) into a 32-bit shadow.
  - Loads from 0x04 return the shadow.
  - Shadow resets to 0; stores to 0x04 write live MTIME and leave the shadow unchanged.
- Undefined: loads from 0x04 return live MTIME[63:32]; no shadow register exists.

Test Plan:
- Reset, then idle → out = 0, irq = 0, access_fault_n = 1, op_fault = 0, addr_fault = 0; load 0x08 word → out = 32'hFFFF_FFFF in the next cycle.
- Store word 0x10 = 1, PRESCALE = 3 → MTIME[31:0] increments once every 4 cycles; after 40 cycles a load of 0x00 reads 10 (±1 per the documented edge).
- Store MTIME = 64'h0000_0000_FFFF_FFFF, PRESCALE = 0, run = 1 → next tick gives MTIME = 64'h0000_0001_0000_0000; load 0x04 → 1.
- Store MTIMECMP = 5, irq_en = 1, run = 1 from MTIME = 0, PRESCALE = 0 → irq rises in the cycle after MTIME reaches 5; store MTIMECMP[31:0] = 100 → irq falls one cycle later.
- Byte store 0xAB at offset 0x0A, then signed byte load of 0x0A → out = 32'hFFFF_FFAB; unsigned byte load → out = 32'h0000_00AB; MTIMECMP[31:0] = 32'hFFAB_FFFF.
- Faults:
  - Half at BASE_ADDR + 1 → addr_fault = 1.
  - op = 11 → op_fault = 1.
  - addr = BASE_ADDR + 32 → access_fault_n = 0.
  - In each case no register changes and out holds its previous value.
